// File: rtl/video_crtc_regs.sv
// 6845-style CRTC register file for the CGA adapter: index/data I/O ports,
// vsync-shadowed start address, and field-rate cursor/character blink.
module video_crtc_regs #(
  parameter logic [11:0] IO_BASE  = 12'h3D0,
  parameter int unsigned FAST_BIT = 3,
  parameter int unsigned SLOW_BIT = 4
) (
  input  logic        iClk,
  input  logic        iRstN,
  input  logic [19:0] iAddr,
  input  logic [7:0]  iWrData,
  input  logic        iWrIo,
  input  logic        iRdIo,
  output logic [7:0]  oRdData,
  output logic        oSel,
  input  logic        iVsync,
  output logic [13:0] oStartAddr,
  output logic [13:0] oCursorAddr,
  output logic [4:0]  oCursorStart,
  output logic [4:0]  oCursorEnd,
  output logic [4:0]  oMaxScanLine,
  output logic        oCursorOn,
  output logic        oCharBlink
);

  logic [7:0] regs [16];
  logic [4:0] index;
  logic       vsPrev;
  logic [4:0] frameCnt;
  logic       hit, idxWr, dataWr, rdClaim, rise, cursorNext;
  logic       unusedAddr;

  function automatic logic [7:0] regMask(input logic [3:0] r);
    case (r)
      4'd4, 4'd6, 4'd7, 4'd10: regMask = 8'h7F;
      4'd5, 4'd9, 4'd11:       regMask = 8'h1F;
      4'd8:                    regMask = 8'h03;
      4'd12, 4'd14:            regMask = 8'h3F;
      default:                 regMask = 8'hFF;
    endcase
  endfunction

  function automatic logic [7:0] regReset(input logic [3:0] r);
    case (r)
      4'd0:    regReset = 8'h71;
      4'd1:    regReset = 8'h50;
      4'd2:    regReset = 8'h5A;
      4'd3:    regReset = 8'h0A;
      4'd4:    regReset = 8'h1F;
      4'd5:    regReset = 8'h06;
      4'd6:    regReset = 8'h19;
      4'd7:    regReset = 8'h1C;
      4'd8:    regReset = 8'h02;
      4'd9:    regReset = 8'h07;
      4'd10:   regReset = 8'h06;
      4'd11:   regReset = 8'h07;
      default: regReset = 8'h00;
    endcase
  endfunction

  assign unusedAddr = ^{iAddr[19:12], iAddr[2:1]};
  assign hit     = (iAddr[11:3] == IO_BASE[11:3]);
  assign idxWr   = hit && iWrIo && !iAddr[0];
  assign dataWr  = hit && iWrIo && iAddr[0];
  assign rdClaim = hit && iRdIo && iAddr[0];
  assign rise    = iVsync && !vsPrev;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= regReset(4'(i));
      index <= '0;
    end else begin
      if (idxWr) index <= iWrData[4:0];
      if (dataWr && !index[4]) regs[index[3:0]] <= iWrData & regMask(index[3:0]);
    end
  end

  // Read data comes from pre-write register contents, so a same-cycle write
  // to the addressed register is not visible until the following read.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oSel    <= 1'b0;
      oRdData <= '0;
    end else begin
      oSel    <= rdClaim;
      oRdData <= (rdClaim && index[4:2] == 3'b011) ? regs[index[3:0]] : '0;
    end
  end

  // The shadow samples R12/R13 before any same-cycle write lands.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      vsPrev     <= 1'b0;
      frameCnt   <= '0;
      oStartAddr <= '0;
    end else begin
      vsPrev <= iVsync;
      if (rise) begin
        frameCnt   <= frameCnt + 5'd1;
        oStartAddr <= {regs[12][5:0], regs[13]};
      end
    end
  end

  always_comb begin
    cursorNext = 1'b1;
    case (regs[10][6:5])
      2'b00: cursorNext = 1'b1;
      2'b01: cursorNext = 1'b0;
      2'b10: cursorNext = frameCnt[FAST_BIT];
      2'b11: cursorNext = frameCnt[SLOW_BIT];
    endcase
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oCursorOn  <= 1'b1;
      oCharBlink <= 1'b0;
    end else begin
      oCursorOn  <= cursorNext;
      oCharBlink <= frameCnt[SLOW_BIT];
    end
  end

  assign oCursorAddr  = {regs[14][5:0], regs[15]};
  assign oCursorStart = regs[10][4:0];
  assign oCursorEnd   = regs[11][4:0];
  assign oMaxScanLine = regs[9][4:0];

endmodule

// File: tb/tb_video_crtc_regs.sv
// Directed plus randomized bench for video_crtc_regs, checked against a
// field-count / register-table reference model.
module tb_video_crtc_regs;

  logic        iClk = 1'b0;
  logic        iRstN = 1'b0;
  logic [19:0] iAddr = '0;
  logic [7:0]  iWrData = '0;
  logic        iWrIo = 1'b0;
  logic        iRdIo = 1'b0;
  logic        iVsync = 1'b0;
  logic [7:0]  oRdData;
  logic        oSel;
  logic [13:0] oStartAddr, oCursorAddr;
  logic [4:0]  oCursorStart, oCursorEnd, oMaxScanLine;
  logic        oCursorOn, oCharBlink;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int widths [16] = '{8, 8, 8, 8, 7, 5, 7, 7, 2, 5, 7, 5, 6, 8, 6, 8};
  int resets [16] = '{'h71, 'h50, 'h5A, 'h0A, 'h1F, 'h06, 'h19, 'h1C,
                      'h02, 'h07, 'h06, 'h07, 0, 0, 0, 0};
  int mReg [16];
  int mIdx;
  int mShadow;
  int mFields;

  video_crtc_regs #(.IO_BASE(12'h3D0), .FAST_BIT(3), .SLOW_BIT(4)) dut (
    .iClk(iClk), .iRstN(iRstN), .iAddr(iAddr), .iWrData(iWrData),
    .iWrIo(iWrIo), .iRdIo(iRdIo), .oRdData(oRdData), .oSel(oSel),
    .iVsync(iVsync), .oStartAddr(oStartAddr), .oCursorAddr(oCursorAddr),
    .oCursorStart(oCursorStart), .oCursorEnd(oCursorEnd),
    .oMaxScanLine(oMaxScanLine), .oCursorOn(oCursorOn), .oCharBlink(oCharBlink)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit isHit(input logic [19:0] a);
    return ((int'(a[11:0]) / 8) == ('h3D0 / 8));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mReg[i] = resets[i];
    mIdx = 0; mShadow = 0; mFields = 0;
  endtask

  task automatic modelWrite(input logic [19:0] a, input logic [7:0] d);
    if (isHit(a)) begin
      if (a[0] == 1'b0) mIdx = int'(d) % 32;
      else if (mIdx < 16) mReg[mIdx] = int'(d) % (1 << widths[mIdx]);
    end
  endtask

  task automatic modelRise();
    mShadow = (mReg[12] % 64) * 256 + mReg[13];
    mFields = mFields + 1;
  endtask

  function automatic int expCursorOn();
    case ((mReg[10] / 32) % 4)
      0: return 1;
      1: return 0;
      2: return (mFields / 8) % 2;
      default: return (mFields / 16) % 2;
    endcase
  endfunction

  task automatic checkNow(input string ctx);
    chk({ctx, ".startAddr"}, 32'(oStartAddr), 32'(mShadow));
    chk({ctx, ".cursorAddr"}, 32'(oCursorAddr), 32'((mReg[14] % 64) * 256 + mReg[15]));
    chk({ctx, ".cursorStart"}, 32'(oCursorStart), 32'(mReg[10] % 32));
    chk({ctx, ".cursorEnd"}, 32'(oCursorEnd), 32'(mReg[11] % 32));
    chk({ctx, ".maxScan"}, 32'(oMaxScanLine), 32'(mReg[9] % 32));
    chk({ctx, ".cursorOn"}, 32'(oCursorOn), 32'(expCursorOn()));
    chk({ctx, ".charBlink"}, 32'(oCharBlink), 32'((mFields / 16) % 2));
    chk({ctx, ".selIdle"}, 32'(oSel), 32'd0);
    chk({ctx, ".rdIdle"}, 32'(oRdData), 32'd0);
  endtask

  task automatic checkAll(input string ctx);
    @(negedge iClk);
    checkNow(ctx);
  endtask

  task automatic ioWrite(input logic [19:0] a, input logic [7:0] d);
    @(negedge iClk);
    iAddr = a; iWrData = d; iWrIo = 1'b1;
    @(negedge iClk);
    iWrIo = 1'b0;
    modelWrite(a, d);
  endtask

  task automatic ioRead(input string tag, input logic [19:0] a);
    int expData;
    bit claim;
    claim = isHit(a) && a[0];
    expData = (claim && mIdx >= 12 && mIdx <= 15) ? mReg[mIdx] : 0;
    @(negedge iClk);
    iAddr = a; iRdIo = 1'b1;
    @(negedge iClk);
    iRdIo = 1'b0;
    chk({tag, ".sel"}, 32'(oSel), 32'(claim));
    chk({tag, ".data"}, 32'(oRdData), 32'(expData));
  endtask

  task automatic vsync();
    @(negedge iClk);
    iVsync = 1'b1;
    @(negedge iClk);
    iVsync = 1'b0;
    modelRise();
  endtask

  task automatic vsyncWithWrite(input logic [19:0] a, input logic [7:0] d);
    @(negedge iClk);
    iVsync = 1'b1; iAddr = a; iWrData = d; iWrIo = 1'b1;
    @(negedge iClk);
    iVsync = 1'b0; iWrIo = 1'b0;
    modelRise();
    modelWrite(a, d);
  endtask

  function automatic logic [19:0] randAddr(input bit wantHit);
    logic [31:0] r;
    logic [19:0] a;
    r = $urandom;
    a[19:12] = r[31:24];
    if (wantHit) a[11:0] = 12'h3D0 + 12'(r[2:0]);
    else begin
      case (r[5:4])
        2'd0: a[11:0] = 12'h3D8 + 12'(r[2:0]);
        2'd1: a[11:0] = 12'h3C8 + 12'(r[2:0]);
        2'd2: a[11:0] = 12'h2D4;
        default: a[11:0] = 12'h7D5;
      endcase
    end
    return a;
  endfunction

  initial begin
    logic [31:0] r;
    logic [7:0] d;
    modelReset();
    repeat (3) @(negedge iClk);
    iRstN = 1'b1;
    checkAll("reset");

    ioWrite(20'h003D4, 8'h0E);
    ioRead("rstR14", 20'h003D5);
    ioWrite(20'h003D4, 8'h0F);
    ioRead("rstR15", 20'h003D5);

    ioWrite(20'h003D4, 8'h0E); ioWrite(20'h003D5, 8'hFF);
    ioWrite(20'h003D4, 8'h0F); ioWrite(20'h003D5, 8'hA5);
    checkAll("curAddr");
    chk("curAddr3FA5", 32'(oCursorAddr), 32'h3FA5);
    ioWrite(20'h003D0, 8'h0E); ioWrite(20'h003D1, 8'h12);
    ioWrite(20'h003D2, 8'h0F); ioWrite(20'h003D3, 8'h34);
    checkAll("mirror");
    ioRead("mirrorRd", 20'h003D7);

    ioWrite(20'h003D4, 8'h0C); ioWrite(20'h003D5, 8'h12);
    ioWrite(20'h003D4, 8'h0D); ioWrite(20'h003D5, 8'h34);
    checkAll("shadowHold");
    vsync();
    checkAll("shadow1");
    chk("shadow1234", 32'(oStartAddr), 32'h1234);
    vsyncWithWrite(20'h003D5, 8'h56);
    checkAll("shadowRace");
    chk("race1234", 32'(oStartAddr), 32'h1234);
    vsync();
    checkAll("shadowNext");
    chk("next1256", 32'(oStartAddr), 32'h1256);

    ioWrite(20'h003D4, 8'h0A); ioWrite(20'h003D5, 8'h46);
    checkAll("fastMode");
    for (int i = 0; i < 20; i++) begin vsync(); checkAll("fastBlink"); end
    ioWrite(20'h003D5, 8'h66);
    checkAll("slowMode");
    for (int i = 0; i < 34; i++) begin vsync(); checkAll("slowBlink"); end
    ioWrite(20'h003D5, 8'h26);
    for (int i = 0; i < 10; i++) begin vsync(); checkAll("cursorOff"); end

    ioWrite(20'h003D4, 8'h10);
    ioRead("lightPen", 20'h003D5);
    ioRead("idxPort", 20'h003D4);
    ioRead("nonHit3D9", 20'h003D9);
    ioWrite(20'h003D4, 8'h14); ioWrite(20'h003D5, 8'hFF);
    checkAll("idx20");
    for (int i = 12; i < 16; i++) begin
      ioWrite(20'h003D4, 8'(i));
      ioRead("idx20Rd", 20'h003D5);
    end

    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      d = r[15:8];
      case (r[3:0])
        4'd0, 4'd1: ioWrite(randAddr(1'b1) & 20'hFFFFE, 8'h0C + 8'(r[17:16]));
        4'd2, 4'd3, 4'd4: ioWrite(randAddr(1'b1), d);
        4'd5: ioWrite(randAddr(1'b1) & 20'hFFFFE, 8'(r[20:16]));
        4'd6, 4'd7, 4'd8: ioRead("rndRd", randAddr(r[24]));
        4'd9, 4'd10: vsync();
        4'd11: ioWrite(randAddr(1'b0), d);
        4'd12: vsyncWithWrite(randAddr(1'b1) | 20'h1, d);
        default: ioWrite(20'h003D5, d);
      endcase
      checkAll("rnd");
    end

    ioWrite(20'h003D4, 8'h0A); ioWrite(20'h003D5, 8'h26);
    ioWrite(20'h003D4, 8'h0C); ioWrite(20'h003D5, 8'h3F);
    vsync();
    checkAll("preRst");
    @(negedge iClk);
    iAddr = 20'h003D5; iRdIo = 1'b1; iRstN = 1'b0;
    #1;
    modelReset();
    checkNow("asyncRst");
    @(negedge iClk);
    iRdIo = 1'b0; iRstN = 1'b1;
    chk("rstDropSel", 32'(oSel), 32'd0);
    checkAll("postRst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_crtc_regs.md
Name: video_crtc_regs

Overview:
- 6845-compatible CRTC register file and cursor/blink timing generator for the CGA adapter.
- Sits directly upstream of the CGA video pipeline, on the CPU I/O bus at ports 3D0–3D7.
- Supplies display start address, cursor position and shape, cursor visibility and character-blink phase to the video stage.
- Implements the index/data register protocol, vsync-synchronised start-address shadowing and a field-rate blink counter.

Parameters:
- IO_BASE, 12'h3D0: base of the 8-port decode window; iAddr[11:3] is compared with IO_BASE[11:3].
- FAST_BIT, 3: frame-counter bit used for fast cursor blink (period 16 fields).
- SLOW_BIT, 4: frame-counter bit used for slow cursor blink and character blink (period 32 fields).

Ports:
- iClk  in  1  CPU-domain clock; all logic is on its rising edge.
- iRstN  in  1  asynchronous active-low reset.
- iAddr  in  20  I/O address; only bits [11:0] are decoded.
- iWrData  in  8  I/O write data.
- iWrIo  in  1  I/O write strobe, one cycle.
- iRdIo  in  1  I/O read strobe, one cycle.
- oRdData  out  8  read data; 0 when oSel=0.
- oSel  out  1  read data valid; pulses 1 cycle after a claimed iRdIo.
- iVsync  in  1  vertical sync, already synchronised to iClk; active high.
- oStartAddr  out  14  shadowed display start address {R12[5:0],R13}.
- oCursorAddr  out  14  cursor address {R14[5:0],R15}.
- oCursorStart  out  5  R10[4:0], first cursor scanline.
- oCursorEnd  out  5  R11[4:0], last cursor scanline.
- oMaxScanLine  out  5  R9[4:0], character height minus 1.
- oCursorOn  out  1  cursor visible this field.
- oCharBlink  out  1  attribute-blink phase.

Behaviour:
- Decode: hit = (iAddr[11:3]==IO_BASE[11:3]). iAddr[0]=0 selects the index port; iAddr[0]=1 selects the data port. This mirrors 3D0/2/4/6 and 3D1/3/5/7.
- Index register: 5 bits, reset 0. An index-port write loads iWrData[4:0]; bits [7:5] are ignored.
- Data write: stores into R[index] masked to register width. Widths: R0–R3 8; R4 7; R5 5; R6 7; R7 7; R8 2; R9 5; R10 7; R11 5; R12 6; R13 8; R14 6; R15 8. Writes to index 16–31 are ignored.
- Reset values (80x25 text): R0 71, R1 50, R2 5A, R3 0A, R4 1F, R5 06, R6 19, R7 1C, R8 02, R9 07, R10 06, R11 07, R12–R15 00 (hex).
- Reads, one-cycle registered latency (oSel and oRdData valid in the cycle after iRdIo):
  - Data port with index 12–15 returns the register value zero-extended.
  - Data port with any other index (including 16/17, light pen) returns 00 with oSel=1.
  - Index-port reads are not claimed: oSel=0, oRdData=0.
  - Non-hit addresses give oSel=0, oRdData=0.
- A read and a write to the same register in the same cycle returns the pre-write value.
- Vsync edge detect: vsPrev is registered, reset 0. rise = iVsync & !vsPrev, a single-cycle event.
- Start-address shadow: oStartAddr loads {R12,R13} on rise, reset 0.
  - A write to R12/R13 in the same cycle as rise is not captured; the shadow takes the old value, and the new value appears at the next rise.
- Frame counter: 5 bits, reset 0. Increments on rise and wraps 31→0.
- oCharBlink = frame counter [SLOW_BIT], registered; toggles every 16 fields.
- Cursor mode R10[6:5]:
  - 00: oCursorOn=1.
  - 01: oCursorOn=0.
  - 10: oCursorOn = frame counter [FAST_BIT].
  - 11: oCursorOn = frame counter [SLOW_BIT].
  - oCursorOn is registered, so a mode change takes effect 1 cycle after the write.
- oCursorAddr, oCursorStart, oCursorEnd, oMaxScanLine are combinational from the register file and change the cycle after the write.
- Reset reachable at any time:
  - All registers, shadow, counter and vsPrev return to reset values immediately.
  - oSel=0, oRdData=0.
  - oCursorOn=1 and oCharBlink=0 (reset mode 00, counter 0).
  - An in-flight read is dropped.
- Reset output values: oStartAddr 0000, oCursorAddr 0000, oCursorStart 06, oCursorEnd 07, oMaxScanLine 07.

Test Plan:
- Reset check: after reset, read R14/R15 via 3D4 index then 3D5 data → oSel=1, oRdData 00 one cycle later. Confirm oCursorStart=6, oCursorEnd=7, oMaxScanLine=7, oCursorOn=1.
- Cursor address and mirror: write 3D4←0E, 3D5←FF, 3D4←0F, 3D5←A5 → oCursorAddr=3FA5 (masked). Mirror port 3D0/3D1 gives the same result.
- Start-address shadow: write R12=12, R13=34 → oStartAddr stays 0000 until the iVsync rise, then 1234. A write of R13=56 coinciding with a rise gives 1234 at that rise and 1256 at the next.
- Blink timing:
  - R10←46 (mode 10): oCursorOn toggles every 8 vsync rises.
  - R10←66 (mode 11): oCursorOn toggles every 16 rises; oCharBlink toggles every 16 rises.
  - R10←26 (mode 01): oCursorOn=0 constantly.
- Read decode: read index 16 → 00 with oSel=1; read 3D4 → oSel=0; read 3D9 → oSel=0; a write to index 20 leaves R0–R15 unchanged.
- Reset mid-operation: assert iRstN low in the same cycle as iRdIo on 3D5 → no oSel pulse, and all outputs return to reset values asynchronously.
